// File: rtl/mem_arbiter_rr.sv
// mem_arbiter_rr: N-port memory-bus arbiter with one shared memory port.
//   Arbitration is either round-robin or fixed priority, where the highest
//   index wins. The winning port gets a registered one-hot grant, its binary
//   id and its read/write direction. Each port has its own wait-state count,
//   fixed by parameter. The access ends with a one-cycle ready strobe, which
//   is driven while the FSM sits in RESP.
//
// Ports:
//   clk            system clock, rising edge
//   rst            asynchronous, active-low reset
//   skip_wait      cut remaining wait states short (fast device hit)
//   read_request   per-port read request, held until ready
//   write_request  per-port write request, held until ready
//   grant          one-hot grant to the winning port
//   grant_id       binary index of the winning port
//   rwbar          1 = read, 0 = write, for the granted port
//   memory_sel     memory chip select, high whenever the FSM is not IDLE
//   ready          access-complete strobe, one cycle wide
module mem_arbiter_rr #(
  parameter int N = 4,
  parameter int WAIT_W = 4,
  parameter logic [N*WAIT_W-1:0] WAIT_STATES = {N{WAIT_W'(2)}},
  parameter bit RR_MODE = 1'b1,
  localparam int ID_W = (N > 1) ? $clog2(N) : 1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            skip_wait,
  input  logic [N-1:0]    read_request,
  input  logic [N-1:0]    write_request,
  output logic [N-1:0]    grant,
  output logic [ID_W-1:0] grant_id,
  output logic            rwbar,
  output logic            memory_sel,
  output logic            ready
);

  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

  state_t            state, state_nxt;
  logic [WAIT_W-1:0] wait_cnt, wait_cnt_nxt;
  logic [ID_W-1:0]   ptr, ptr_nxt;
  logic [N-1:0]      grant_nxt;
  logic [ID_W-1:0]   grant_id_nxt;
  logic              rwbar_nxt, memory_sel_nxt, ready_nxt;

  logic [N-1:0]      req;
  logic              win_found;
  logic [ID_W-1:0]   win_id;
  logic [WAIT_W-1:0] win_wait;
  int                rr_idx;

  assign req = read_request | write_request;

  // Winner selection. Round-robin scans upward from ptr+1, wrapping modulo N,
  // and the first hit wins. Fixed mode keeps the last hit of an ascending
  // scan, so the highest asserted index wins.
  always_comb begin
    win_found = 1'b0;
    win_id    = '0;
    rr_idx    = 0;
    if (RR_MODE) begin
      for (int k = 1; k <= N; k++) begin
        rr_idx = (int'(ptr) + k) % N;
        if (!win_found && req[rr_idx]) begin
          win_found = 1'b1;
          win_id    = ID_W'(rr_idx);
        end
      end
    end else begin
      for (int i = 0; i < N; i++) begin
        if (req[i]) begin
          win_found = 1'b1;
          win_id    = ID_W'(i);
        end
      end
    end
  end

  assign win_wait = WAIT_STATES[int'(win_id)*WAIT_W +: WAIT_W];

  // Next-state and next-output logic. Every output is registered, so the
  // values computed here appear on the ports after the following edge.
  always_comb begin
    state_nxt      = state;
    wait_cnt_nxt   = wait_cnt;
    ptr_nxt        = ptr;
    grant_nxt      = grant;
    grant_id_nxt   = grant_id;
    rwbar_nxt      = rwbar;
    memory_sel_nxt = memory_sel;
    ready_nxt      = 1'b0;
    unique case (state)
      IDLE: begin
        grant_nxt      = '0;
        grant_id_nxt   = '0;
        rwbar_nxt      = 1'b0;
        memory_sel_nxt = 1'b0;
        wait_cnt_nxt   = '0;
        if (win_found) begin
          grant_nxt[win_id] = 1'b1;
          grant_id_nxt      = win_id;
          // A port asserting both read and write is served as a read.
          rwbar_nxt         = read_request[win_id];
          memory_sel_nxt    = 1'b1;
          ptr_nxt           = win_id;
          if (win_wait == '0 || skip_wait) begin
            ready_nxt = 1'b1;
            state_nxt = RESP;
          end else begin
            wait_cnt_nxt = win_wait;
            state_nxt    = WAIT;
          end
        end
      end
      WAIT: begin
        // wait_cnt is never 0 here. Leaving at 1 means it cannot underflow.
        if (wait_cnt == WAIT_W'(1) || skip_wait) begin
          ready_nxt    = 1'b1;
          wait_cnt_nxt = '0;
          state_nxt    = RESP;
        end else begin
          wait_cnt_nxt = wait_cnt - WAIT_W'(1);
        end
      end
      RESP: begin
        grant_nxt      = '0;
        grant_id_nxt   = '0;
        rwbar_nxt      = 1'b0;
        memory_sel_nxt = 1'b0;
        state_nxt      = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= IDLE;
      wait_cnt   <= '0;
      ptr        <= ID_W'(N - 1);
      grant      <= '0;
      grant_id   <= '0;
      rwbar      <= 1'b0;
      memory_sel <= 1'b0;
      ready      <= 1'b0;
    end else begin
      state      <= state_nxt;
      wait_cnt   <= wait_cnt_nxt;
      ptr        <= ptr_nxt;
      grant      <= grant_nxt;
      grant_id   <= grant_id_nxt;
      rwbar      <= rwbar_nxt;
      memory_sel <= memory_sel_nxt;
      ready      <= ready_nxt;
    end
  end

endmodule

// File: tb/tb_mem_arbiter_rr.sv
// tb_mem_arbiter_rr: directed bench for mem_arbiter_rr. It uses N=4 with
// wait states p3..p0 = 3,2,1,0. One instance runs in round-robin mode and a
// second instance runs in fixed-priority mode. Both share the same stimulus.
module tb_mem_arbiter_rr;

  logic       clk;
  logic       rst;
  logic       skip_wait;
  logic [3:0] read_request;
  logic [3:0] write_request;

  logic [3:0] grant,      grant_fx;
  logic [1:0] grant_id,   grant_id_fx;
  logic       rwbar,      rwbar_fx;
  logic       memory_sel, memory_sel_fx;
  logic       ready,      ready_fx;

  int n_vec = 0;
  int n_err = 0;

  mem_arbiter_rr #(.N(4), .WAIT_W(4), .WAIT_STATES(16'h3210), .RR_MODE(1'b1)) dut (
    .clk(clk), .rst(rst), .skip_wait(skip_wait),
    .read_request(read_request), .write_request(write_request),
    .grant(grant), .grant_id(grant_id), .rwbar(rwbar),
    .memory_sel(memory_sel), .ready(ready)
  );

  mem_arbiter_rr #(.N(4), .WAIT_W(4), .WAIT_STATES(16'h3210), .RR_MODE(1'b0)) dut_fx (
    .clk(clk), .rst(rst), .skip_wait(skip_wait),
    .read_request(read_request), .write_request(write_request),
    .grant(grant_fx), .grant_id(grant_id_fx), .rwbar(rwbar_fx),
    .memory_sel(memory_sel_fx), .ready(ready_fx)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Round-robin schedule with all four ports requesting, one entry per edge.
  logic [3:0] rr_grant [15] = '{4'h1, 4'h0, 4'h2, 4'h2, 4'h0, 4'h4, 4'h4, 4'h4,
                                4'h0, 4'h8, 4'h8, 4'h8, 4'h8, 4'h0, 4'h1};
  logic       rr_ready [15] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1,
                                1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
  logic [1:0] rr_id    [15] = '{2'd0, 2'd0, 2'd1, 2'd1, 2'd0, 2'd2, 2'd2, 2'd2,
                                2'd0, 2'd3, 2'd3, 2'd3, 2'd3, 2'd0, 2'd0};
  // Fixed priority with ports 1 and 3 requesting: port 3 wins every time.
  logic [3:0] fx_grant [11] = '{4'h8, 4'h8, 4'h8, 4'h8, 4'h0, 4'h8, 4'h8, 4'h8,
                                4'h8, 4'h0, 4'h8};

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Advance one clock and settle just after the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst           = 1'b0;
    skip_wait     = 1'b0;
    read_request  = '0;
    write_request = '0;
    #2;
    rst = 1'b1;
  endtask

  initial begin
    rst           = 1'b0;
    skip_wait     = 1'b0;
    read_request  = '0;
    write_request = '0;
    #12;
    chk("rst_grant", 32'(grant), 32'h0);
    chk("rst_ready", 32'(ready), 32'h0);
    chk("rst_msel",  32'(memory_sel), 32'h0);
    chk("rst_rwbar", 32'(rwbar), 32'h0);
    chk("rst_gid",   32'(grant_id), 32'h0);
    rst = 1'b1;

    // 1. Asynchronous reset in the middle of a WAIT on port 2.
    tick();
    read_request = 4'b0100;
    tick();
    chk("t1_grant_p2", 32'(grant), 32'h4);
    chk("t1_ready_p2", 32'(ready), 32'h0);
    rst = 1'b0;
    #1;
    chk("t1_abort_grant", 32'(grant), 32'h0);
    chk("t1_abort_msel",  32'(memory_sel), 32'h0);
    chk("t1_abort_ready", 32'(ready), 32'h0);
    read_request = 4'b0001;
    #1;
    rst = 1'b1;
    tick();
    chk("t1_p0_grant", 32'(grant), 32'h1);
    chk("t1_p0_ready", 32'(ready), 32'h1);
    chk("t1_p0_rwbar", 32'(rwbar), 32'h1);
    chk("t1_p0_msel",  32'(memory_sel), 32'h1);
    read_request = '0;
    tick();
    chk("t1_resp_grant", 32'(grant), 32'h0);
    chk("t1_resp_ready", 32'(ready), 32'h0);
    chk("t1_resp_msel",  32'(memory_sel), 32'h0);

    // 2. Port 3 write with three wait states.
    do_reset();
    write_request = 4'b1000;
    tick();
    chk("t2_grant", 32'(grant), 32'h8);
    chk("t2_gid",   32'(grant_id), 32'h3);
    chk("t2_rwbar", 32'(rwbar), 32'h0);
    chk("t2_rdy0",  32'(ready), 32'h0);
    tick();
    chk("t2_rdy1",  32'(ready), 32'h0);
    tick();
    chk("t2_rdy2",  32'(ready), 32'h0);
    tick();
    chk("t2_rdy3",  32'(ready), 32'h1);
    chk("t2_hold",  32'(grant), 32'h8);
    write_request = '0;
    tick();
    chk("t2_drop_grant", 32'(grant), 32'h0);
    chk("t2_drop_ready", 32'(ready), 32'h0);

    // 3. Round-robin order with all ports requesting continuously.
    do_reset();
    read_request = 4'b1111;
    for (int e = 0; e < 15; e++) begin
      tick();
      chk($sformatf("t3_grant_e%0d", e + 1), 32'(grant), 32'(rr_grant[e]));
      chk($sformatf("t3_ready_e%0d", e + 1), 32'(ready), 32'(rr_ready[e]));
      if (rr_grant[e] != 4'h0)
        chk($sformatf("t3_gid_e%0d", e + 1), 32'(grant_id), 32'(rr_id[e]));
    end

    // 4. Fixed priority: port 3 always beats port 1.
    do_reset();
    read_request = 4'b1010;
    for (int e = 0; e < 11; e++) begin
      tick();
      chk($sformatf("t4_grant_e%0d", e + 1), 32'(grant_fx), 32'(fx_grant[e]));
    end

    // 5. skip_wait during WAIT, then skip_wait already high in IDLE.
    do_reset();
    read_request = 4'b1000;
    tick();
    chk("t5_grant", 32'(grant), 32'h8);
    chk("t5_rwbar", 32'(rwbar), 32'h1);
    chk("t5_rdy0",  32'(ready), 32'h0);
    skip_wait = 1'b1;
    tick();
    chk("t5_skip_ready", 32'(ready), 32'h1);
    skip_wait    = 1'b0;
    read_request = '0;
    tick();
    chk("t5_idle_grant", 32'(grant), 32'h0);
    chk("t5_idle_ready", 32'(ready), 32'h0);
    skip_wait    = 1'b1;
    read_request = 4'b1000;
    tick();
    chk("t5_idle_skip_grant", 32'(grant), 32'h8);
    chk("t5_idle_skip_ready", 32'(ready), 32'h1);
    skip_wait    = 1'b0;
    read_request = '0;
    tick();
    chk("t5_end_ready", 32'(ready), 32'h0);

    // 6. Port 2 requests read and write together, then drops during WAIT.
    do_reset();
    read_request  = 4'b0100;
    write_request = 4'b0100;
    tick();
    chk("t6_grant", 32'(grant), 32'h4);
    chk("t6_rwbar", 32'(rwbar), 32'h1);
    read_request  = '0;
    write_request = '0;
    tick();
    chk("t6_rdy1",  32'(ready), 32'h0);
    tick();
    chk("t6_rdy2",  32'(ready), 32'h1);
    chk("t6_hold",  32'(grant), 32'h4);
    tick();
    chk("t6_end_grant", 32'(grant), 32'h0);
    chk("t6_end_ready", 32'(ready), 32'h0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
